// File: rtl/pq_pkg.sv
// Shared types for the sorted-register priority queue: per-slot shift select and slot layout.
// The slot struct is width-parameterised through a macro so each module can stamp its own W.
`ifndef PQ_SLOT_T
`define PQ_SLOT_T(WIDTH) struct packed { logic valid; logic [(WIDTH)-1:0] key; }
`endif

package pq_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        TAKE_NEW  = 2'd1,
        TAKE_UP   = 2'd2,
        TAKE_DOWN = 2'd3
    } shift_sel_e;

endpackage

// File: rtl/pq_slot.sv
// One priority-queue entry: registered {valid,key} with a 4-way next-state mux and a >= compare
// against the incoming key; state is visible one cycle after the select is applied.
module pq_slot
    import pq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         r,
    input  logic         clear,
    input  shift_sel_e   sel,
    input  logic [W-1:0] in_val,
    input  logic [W:0]   up_dat,
    input  logic [W:0]   down_dat,
    output logic [W:0]   slot_dat,
    output logic         ge
);

    typedef `PQ_SLOT_T(W) slot_t;

    slot_t slot_q;
    slot_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clear) begin
            slot_d = '0;
        end else begin
            case (sel)
                TAKE_NEW: begin
                    slot_d.valid = 1'b1;
                    slot_d.key   = in_val;
                end
                TAKE_UP:   slot_d = up_dat;
                TAKE_DOWN: slot_d = down_dat;
                default:   slot_d = slot_q;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (r) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_dat = slot_q;
    // Invalid slots never compare >=, so the ge vector is a run of ones from slot 0.
    assign ge = slot_q.valid && (slot_q.key >= in_val);

endmodule

// File: rtl/pri_queue_n.sv
// Sorted-register max priority queue; push/pop visible next cycle, in_ready = ~full | out_ready.
// PQ_OVERWRITE_EN: in_ready tied high, full push without pop evicts the smallest key and pulses dropped.
module pri_queue_n
    import pq_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int DEPTH = 6,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             ck,
    input  logic             r,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
`ifdef PQ_OVERWRITE_EN
    ,
    output logic             dropped
`endif
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [W:0]       slot_dat [DEPTH];
    logic [DEPTH-1:0] ge;
    logic [DEPTH-1:0] ge_prev;
    logic [DEPTH-1:0] ge_next;
    logic [DEPTH-1:0] first;
    shift_sel_e       sel [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;
    assign count     = count_q;
    assign top       = slot_dat[0][W-1:0];

`ifdef PQ_OVERWRITE_EN
    assign in_ready = 1'b1;
`else
    assign in_ready = ~full | out_ready;
`endif

    assign do_push = in_valid & in_ready;
    assign do_pop  = out_valid & out_ready;

    assign ge_prev = {ge[DEPTH-2:0], 1'b1};
    assign ge_next = {1'b0, ge[DEPTH-1:1]};
    assign first   = {{(DEPTH-1){1'b0}}, 1'b1};

    // With pop+push the top leaves first, so the new key lands one slot earlier than a plain push.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = HOLD;
            if (do_push && do_pop) begin
                if (ge_next[i])              sel[i] = TAKE_UP;
                else if (ge[i] || first[i])  sel[i] = TAKE_NEW;
                else                         sel[i] = HOLD;
            end else if (do_push) begin
                if (ge[i])                   sel[i] = HOLD;
                else if (ge_prev[i])         sel[i] = TAKE_NEW;
                else                         sel[i] = TAKE_DOWN;
            end else if (do_pop) begin
                sel[i] = TAKE_UP;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (do_push && !do_pop && !full) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge ck) begin
        if (r) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef PQ_OVERWRITE_EN
    logic dropped_q;
    logic dropped_d;

    always_comb begin
        dropped_d = ~clear & do_push & ~do_pop & full;
    end

    always_ff @(posedge ck) begin
        if (r) begin
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign dropped = dropped_q;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [W:0] up_dat;
        logic [W:0] down_dat;

        if (i == DEPTH - 1) begin : g_last
            assign up_dat = '0;
        end else begin : g_mid
            assign up_dat = slot_dat[i+1];
        end

        if (i == 0) begin : g_head
            assign down_dat = '0;
        end else begin : g_rest
            assign down_dat = slot_dat[i-1];
        end

        pq_slot #(.W(W)) u_slot (
            .ck       (ck),
            .r        (r),
            .clear    (clear),
            .sel      (sel[i]),
            .in_val   (in_val),
            .up_dat   (up_dat),
            .down_dat (down_dat),
            .slot_dat (slot_dat[i]),
            .ge       (ge[i])
        );
    end

endmodule

// File: tb/tb_pri_queue_n.sv
// Bench for pri_queue_n (W=8, DEPTH=6): queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pri_queue_n;

    localparam int W     = 8;
    localparam int DEPTH = 6;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             ck = 1'b0;
    logic             r = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_val = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     top;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
`ifdef PQ_OVERWRITE_EN
    logic             dropped;
`endif

    pri_queue_n #(.W(W), .DEPTH(DEPTH)) dut (
        .ck        (ck),
        .r         (r),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .top       (top),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef PQ_OVERWRITE_EN
        ,
        .dropped   (dropped)
`endif
    );

    always #5 ck = ~ck;

    int tests = 0;
    int fails = 0;

    // Reference model: keys kept largest-first; equal keys keep arrival order.
    int mq[$];
    int exp_dropped = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_in_ready(input logic ordy);
`ifdef PQ_OVERWRITE_EN
        return 1;
`else
        return (mq.size() < DEPTH || ordy) ? 1 : 0;
`endif
    endfunction

    function automatic void model_insert(input int v);
        int pos = 0;
        foreach (mq[k]) if (mq[k] >= v) pos++;
        mq.insert(pos, v);
    endfunction

    function automatic void model_update(input logic rr, input logic cl, input logic iv,
                                         input int v, input logic ordy);
        logic push;
        logic pop;
        exp_dropped = 0;
        if (rr || cl) begin
            mq.delete();
            return;
        end
        push = iv && (model_in_ready(ordy) != 0);
        pop  = ordy && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) begin
                model_insert(v);
            end else begin
                exp_dropped = 1;
                if (v > mq[$]) begin
                    void'(mq.pop_back());
                    model_insert(v);
                end
            end
        end
    endfunction

    // Per-cycle comparison of every observable output against the model.
    task automatic compare_all(input logic ordy);
        int exp_top;
        exp_top = (mq.size() > 0) ? mq[0] : 0;
        chk("top",       int'(top),       exp_top);
        chk("count",     int'(count),     mq.size());
        chk("full",      int'(full),      (mq.size() == DEPTH) ? 1 : 0);
        chk("empty",     int'(empty),     (mq.size() == 0) ? 1 : 0);
        chk("out_valid", int'(out_valid), (mq.size() != 0) ? 1 : 0);
        chk("in_ready",  int'(in_ready),  model_in_ready(ordy));
`ifdef PQ_OVERWRITE_EN
        chk("dropped",   int'(dropped),   exp_dropped);
`endif
    endtask

    task automatic step(input logic rr, input logic cl, input logic iv, input int v,
                        input logic ordy);
        r         = rr;
        clear     = cl;
        in_valid  = iv;
        in_val    = W'(v);
        out_ready = ordy;
        @(negedge ck);
        compare_all(ordy);
        @(posedge ck);
        model_update(rr, cl, iv, v, ordy);
        #1;
        r         = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_val    = '0;
        out_ready = 1'b0;
    endtask

    task automatic push(input int v);
        step(1'b0, 1'b0, 1'b1, v, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int seq1[4];
        seq1 = '{5, 9, 3, 9};

        // Reset values
        do_reset();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_top", int'(top), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Scenario 1: push 5,9,3,9 then drain
        foreach (seq1[k]) push(seq1[k]);
        chk("s1_count", int'(count), 4);
        chk("s1_top", int'(top), 9);
        pop(); chk("s1_pop1_top", int'(top), 9);
        pop(); chk("s1_pop2_top", int'(top), 5);
        pop(); chk("s1_pop3_top", int'(top), 3);
        pop(); chk("s1_pop4_empty", int'(empty), 1);
        chk("s1_pop4_top", int'(top), 0);

        // Scenario 2: fill, then push when full
        for (int v = 10; v <= 60; v += 10) push(v);
        chk("s2_full", int'(full), 1);
        chk("s2_top", int'(top), 60);
`ifdef PQ_OVERWRITE_EN
        push(70);
        chk("s2_ow_top", int'(top), 70);
        chk("s2_ow_count", int'(count), 6);
        chk("s2_ow_dropped", int'(dropped), 1);
        push(5);
        chk("s2_ow_dropped2", int'(dropped), 1);
        chk("s2_ow_top2", int'(top), 70);
`else
        chk("s2_in_ready", int'(in_ready), 0);
        push(70);
        chk("s2_top_after", int'(top), 60);
        chk("s2_count_after", int'(count), 6);
`endif

        // Scenario 3: simultaneous push+pop
        do_reset();
        push(40); push(30); push(20);
        step(1'b0, 1'b0, 1'b1, 25, 1'b1);
        chk("s3_top", int'(top), 30);
        chk("s3_count", int'(count), 3);
        pop(); chk("s3_next", int'(top), 25);
        pop(); chk("s3_last", int'(top), 20);

        // Scenario 4: pop when empty, push+pop when empty
        do_reset();
        pop();
        chk("s4_count", int'(count), 0);
        chk("s4_empty", int'(empty), 1);
        step(1'b0, 1'b0, 1'b1, 7, 1'b1);
        chk("s4_pp_count", int'(count), 1);
        chk("s4_pp_top", int'(top), 7);

        // Scenario 5: clear overrides push
        do_reset();
        push(8); push(4);
        step(1'b0, 1'b1, 1'b1, 99, 1'b0);
        chk("s5_count", int'(count), 0);
        chk("s5_empty", int'(empty), 1);
        chk("s5_top", int'(top), 0);

        // Scenario 6: reset on a full queue with push and pop asserted
        for (int v = 1; v <= DEPTH; v++) push(v * 3);
        chk("s6_full", int'(full), 1);
        step(1'b1, 1'b0, 1'b1, 1, 1'b1);
        chk("s6_count", int'(count), 0);
        chk("s6_full_after", int'(full), 0);
        chk("s6_empty", int'(empty), 1);
        chk("s6_top", int'(top), 0);
        chk("s6_in_ready", int'(in_ready), 1);

        // Randomized traffic, biased toward small keys for ties and toward full/empty boundaries
        for (int n = 0; n < 4000; n++) begin
            logic rr, cl, iv, ordy;
            int   v;
            int   phase;
            phase = (n / 200) % 3;
            rr   = ($urandom_range(0, 299) == 0);
            cl   = ($urandom_range(0, 149) == 0);
            iv   = ($urandom_range(0, 99) < (phase == 0 ? 80 : (phase == 1 ? 30 : 55)));
            ordy = ($urandom_range(0, 99) < (phase == 0 ? 25 : (phase == 1 ? 75 : 50)));
            v    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            step(rr, cl, iv, v, ordy);
        end
        @(negedge ck);
        compare_all(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
